an_sec_decode_ctrl: RTL and testbench
=====================================

# an_sec_decode_ctrl

Sequencing controller for single-error correction of product (AN) codewords with A = 6311 and 20-bit data in 33-bit codewords. It accepts one received codeword at a time over a valid/ready handshake and computes quotient and remainder with a bit-serial restoring divider. It maps the remainder to an error location through the existing `SEC_rLUT20bits` location LUT, applies the ±2^(|l|−1) correction, re-divides to recover data, and reports status. It sits between the memory/ALU read path and the consumer of protected 20-bit data, and keeps saturating error counters for the host.

## Interface
- `CNT_W`, default 16: width of each saturating error counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: received codeword valid.
- `in_ready` out 1: controller idle, can accept a codeword.
- `in_cw` in 33: received codeword.
- `out_valid` out 1: result valid; held until accepted.
- `out_ready` in 1: consumer accepts result.
- `out_data` out 20: decoded data.
- `out_cw` out 33: corrected codeword; equals the received word when uncorrectable.
- `out_status` out 2: 00 clean, 01 corrected, 10 uncorrectable; 11 never driven.
- `out_loc` out 7, signed: error location from LUT; 0 when clean or uncorrectable.
- `cnt_clr` in 1: synchronous clear of both counters.
- `corr_cnt` out CNT_W: count of corrected words, saturating.
- `unc_cnt` out CNT_W: count of uncorrectable words, saturating.

## Operation
- FSM states: IDLE, DIV1, LUT, FIX, DIV2, DONE.
  - IDLE: `in_ready`=1. On `in_valid`&`in_ready`, latch `in_cw` into `rx`, clear `r`/`q`/bit counter, and go to DIV1.
- Serial divide step, shared by DIV1 and DIV2, MSB first, 33 steps:
  - t = {r, bit}, 14 bits.
  - If t ≥ 6311: r ← t − 6311, qbit = 1; else r ← t, qbit = 0.
  - q shifts left, taking qbit.
  - r stays below 6311, so 13 bits suffice after each step.
- DIV1: divides `rx`. After step 33, go to LUT.
- LUT: `SEC_rLUT20bits` is driven combinationally from `r`; register `l`.
  - r = 0: status clean. Go to DONE with data = q[19:0] and `out_cw` = `rx`.
  - r ≠ 0 and l = 0: status uncorrectable. Go to DONE with data = q[19:0].
  - Otherwise, go to FIX.
- Range check: in any path, q[32:20] ≠ 0 forces status uncorrectable.
- FIX: compute a 34-bit value `fx`.
  - l > 0: fx = rx − 2^(l−1).
  - l < 0: fx = rx + 2^(−l−1).
  - If fx[33] = 1 (borrow or overflow): status uncorrectable, go to DONE with `out_cw` = `rx` and data = DIV1 q[19:0].
  - Otherwise, `cw` ← fx[32:0] and go to DIV2.
- DIV2: divides the corrected `cw`.
  - At the end, remainder must be 0; a nonzero remainder is a design error, covered by an assertion.
  - data = q[19:0]. Status is corrected, unless q[32:20] ≠ 0, which gives uncorrectable.
- DONE: `out_valid`=1 with all out_* registered and stable.
  - On `out_ready`, go to IDLE.
  - Counters update on the same edge as the DONE handshake: corrected increments `corr_cnt`, uncorrectable increments `unc_cnt`.
- Counters saturate at all-ones.
  - `cnt_clr` has priority over an increment in the same cycle; that word is not counted.
- No input is accepted while busy; there is no pipelining or overlap.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state is IDLE, `in_ready`=1 after the edge, `out_valid`=0.
  - `out_data`, `out_cw`, `out_status`, `out_loc`, and both counters are 0.
  - A reset in mid-operation drops the word in flight and counts nothing.
- Latency, counted from the accepting edge E0 to the first cycle with `out_valid`=1:
  - clean or uncorrectable after LUT: 34 cycles (DIV1 = 33, LUT = 1);
  - uncorrectable in FIX: 35 cycles;
  - corrected: 68 cycles (33 + 1 + 1 + 33).
- Throughput:
  - `in_ready` returns 1 in the cycle after the output handshake.
  - With `out_ready` held at 1, the next accept comes at the earliest 1 cycle after DONE.
- `out_*` do not change while `out_valid`=1 and `out_ready`=0.

## Structure
- Package `an_code_pkg`:
  - constants `AN_A` = 6311, `AN_A_W` = 13, `AN_DATA_W` = 20, `AN_CW_W` = 33;
  - status encoding constants;
  - FSM state enum.
- The LUT encodes A = 6311 with 33 locations, so these constants are not parameters.
- Sub-module `an_serdiv_step`: combinational one-step restoring divide (r, bit → r', qbit), instantiated once and shared by DIV1 and DIV2.
- `SEC_rLUT20bits` is instantiated unchanged.

## Test plan
- **Clean:** `in_cw` = 31555 (data 5) → status 00, data 5, `out_cw` 31555, `out_loc` 0, `out_valid` at cycle 34.
- **Positive error:** `in_cw` = 39747 (31555 + 2^13, r = 1881) → `out_loc` +14, `out_cw` 31555, data 5, status 01, cycle 68, `corr_cnt` = 1.
- **Negative error:** `in_cw` = 6310999 (6311000 − 1) → `out_loc` −1, `out_cw` 6311000, data 1000, status 01.
- **Uncorrectable:** `in_cw` = 31558 (r = 3, not in LUT) → status 10, data 5, `out_cw` 31558, `unc_cnt` increments, cycle 34.
- **Backpressure and reset:**
  - hold `out_ready`=0 for 10 cycles in DONE → outputs stable, `in_ready`=0;
  - assert `rst_n`=0 mid-DIV2 → all outputs and counters 0, next word decodes correctly.
- **Counters:** with `CNT_W`=2, send 5 corrected words → `corr_cnt` stays 3; `cnt_clr` together with an increment → 0.

Source files
------------

// File: rtl/an_code_pkg.sv
// rtl/an_code_pkg.sv - shared constants, status codes and FSM states for the AN-code decoder
//
// Purpose: constants of the A = 6311 product code (20-bit data, 33-bit
// codewords), the 2-bit status encoding and the controller state enum.
package an_code_pkg;

  localparam int unsigned AN_A      = 6311;
  localparam int unsigned AN_A_W    = 13;
  localparam int unsigned AN_DATA_W = 20;
  localparam int unsigned AN_CW_W   = 33;

  localparam logic [1:0] ST_CLEAN = 2'b00;
  localparam logic [1:0] ST_CORR  = 2'b01;
  localparam logic [1:0] ST_UNC   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV1,
    S_LUT,
    S_FIX,
    S_DIV2,
    S_DONE
  } state_t;

endpackage

// File: rtl/SEC_rLUT20bits.sv
// rtl/SEC_rLUT20bits.sv - remainder to single-error location lookup for A = 6311
//
// Purpose: a remainder r that equals 2^i mod A marks a +2^i error
// (location +(i+1)); r equal to A - (2^i mod A) marks a -2^i error
// (location -(i+1)). Any other remainder yields 0 (not locatable).
// Ports:
//   r  remainder of the received word modulo 6311
//   l  signed error location, 0 when r is not a single-error syndrome
module SEC_rLUT20bits (
  input  logic [12:0]       r,
  output logic signed [6:0] l
);

  always_comb begin : lut_search
    int p;
    l = '0;
    p = 1;
    // Walks 2^i mod A for the 33 bit positions; the loop unrolls into
    // constant comparators.
    for (int i = 0; i < 33; i++) begin
      if (int'(r) == p) begin
        l = 7'(i + 1);
      end else if (int'(r) == 6311 - p) begin
        l = 7'(-(i + 1));
      end
      p = (p * 2) % 6311;
    end
  end

endmodule

// File: rtl/an_serdiv_step.sv
// rtl/an_serdiv_step.sv - one combinational step of a restoring divide by A
//
// Purpose: shifts the next dividend bit into the partial remainder and
// subtracts A when possible.
// Ports:
//   r_i   partial remainder, always < A
//   bit_i next dividend bit (MSB first)
//   r_o   updated remainder, < A
//   q_o   quotient bit produced by this step
module an_serdiv_step
  import an_code_pkg::*;
(
  input  logic [AN_A_W-1:0] r_i,
  input  logic              bit_i,
  output logic [AN_A_W-1:0] r_o,
  output logic              q_o
);

  localparam logic [AN_A_W:0] A_EXT = AN_A[AN_A_W:0];

  logic [AN_A_W:0] t;

  assign t   = {r_i, bit_i};
  assign q_o = (t >= A_EXT);
  // t < 2A, so after a subtraction the result still fits in AN_A_W bits.
  assign r_o = q_o ? AN_A_W'(t - A_EXT) : t[AN_A_W-1:0];

endmodule

// File: rtl/an_sec_decode_ctrl.sv
// rtl/an_sec_decode_ctrl.sv - single-error-correcting AN-code decode controller
//
// Purpose: accepts one 33-bit codeword, divides it by A bit-serially,
// locates and corrects a single arithmetic error, re-divides to recover
// the 20-bit data and reports status, with saturating error counters.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     codeword handshake, in_cw received codeword
//   out_valid/out_ready   result handshake
//   out_data/out_cw       decoded data, corrected (or received) codeword
//   out_status/out_loc    00 clean / 01 corrected / 10 uncorrectable, location
//   cnt_clr               clears both counters
//   corr_cnt/unc_cnt      saturating corrected / uncorrectable counts
module an_sec_decode_ctrl
  import an_code_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AN_CW_W-1:0]   in_cw,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AN_DATA_W-1:0] out_data,
  output logic [AN_CW_W-1:0]   out_cw,
  output logic [1:0]           out_status,
  output logic signed [6:0]    out_loc,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     corr_cnt,
  output logic [CNT_W-1:0]     unc_cnt
);

  localparam logic [5:0] LAST_STEP = 6'(AN_CW_W - 1);

  state_t                state_q, state_d;
  logic [AN_CW_W-1:0]    rx_q, rx_d;
  logic [AN_CW_W-1:0]    cw_q, cw_d;
  logic [AN_A_W-1:0]     r_q, r_d;
  logic [AN_CW_W-1:0]    q_q, q_d;
  logic [5:0]            cnt_q, cnt_d;
  logic signed [6:0]     l_q, l_d;
  logic [AN_DATA_W-1:0]  od_q, od_d;
  logic [AN_CW_W-1:0]    ocw_q, ocw_d;
  logic [1:0]            ost_q, ost_d;
  logic signed [6:0]     oloc_q, oloc_d;
  logic [CNT_W-1:0]      corr_q, corr_d;
  logic [CNT_W-1:0]      unc_q, unc_d;

  // Shared divider datapath: DIV2 divides the corrected word, DIV1 the received one.
  logic [AN_CW_W-1:0] div_src;
  logic [5:0]         bit_idx;
  logic               div_bit;
  logic [AN_A_W-1:0]  step_rem;
  logic               step_qbit;
  logic [AN_CW_W-1:0] q_shift;
  logic               last_step;

  assign div_src   = (state_q == S_DIV2) ? cw_q : rx_q;
  assign bit_idx   = LAST_STEP - cnt_q;
  assign div_bit   = div_src[bit_idx];
  assign q_shift   = {q_q[AN_CW_W-2:0], step_qbit};
  assign last_step = (cnt_q == LAST_STEP);

  an_serdiv_step u_step (
    .r_i   (r_q),
    .bit_i (div_bit),
    .r_o   (step_rem),
    .q_o   (step_qbit)
  );

  logic signed [6:0] lut_l;

  SEC_rLUT20bits u_lut (
    .r (r_q),
    .l (lut_l)
  );

  // Correction: a positive location means the word picked up +2^(l-1),
  // so subtract it; a negative one means it lost 2^(-l-1), so add it back.
  // The extra top bit catches a borrow below zero or a carry past 33 bits.
  logic signed [6:0] l_neg;
  logic [5:0]        shamt;
  logic [AN_CW_W:0]  pow2;
  logic [AN_CW_W:0]  fx;

  assign l_neg = -l_q;
  assign shamt = l_q[6] ? 6'(l_neg - 7'sd1) : 6'(l_q - 7'sd1);
  assign pow2  = {{AN_CW_W{1'b0}}, 1'b1} << shamt;
  assign fx    = l_q[6] ? ({1'b0, rx_q} + pow2) : ({1'b0, rx_q} - pow2);

  logic q_hi_nz;
  logic qs_hi_nz;

  assign q_hi_nz  = |q_q[AN_CW_W-1:AN_DATA_W];
  assign qs_hi_nz = |q_shift[AN_CW_W-1:AN_DATA_W];

  always_comb begin
    state_d = state_q;
    rx_d    = rx_q;
    cw_d    = cw_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    od_d    = od_q;
    ocw_d   = ocw_q;
    ost_d   = ost_q;
    oloc_d  = oloc_q;
    corr_d  = corr_q;
    unc_d   = unc_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          rx_d    = in_cw;
          r_d     = '0;
          q_d     = '0;
          cnt_d   = '0;
          state_d = S_DIV1;
        end
      end
      S_DIV1: begin
        r_d   = step_rem;
        q_d   = q_shift;
        cnt_d = cnt_q + 6'd1;
        if (last_step) begin
          state_d = S_LUT;
        end
      end
      S_LUT: begin
        l_d = lut_l;
        if (r_q == '0 || lut_l == 7'sd0) begin
          od_d    = q_q[AN_DATA_W-1:0];
          ocw_d   = rx_q;
          oloc_d  = '0;
          ost_d   = (r_q == '0 && !q_hi_nz) ? ST_CLEAN : ST_UNC;
          state_d = S_DONE;
        end else begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (fx[AN_CW_W]) begin
          od_d    = q_q[AN_DATA_W-1:0];
          ocw_d   = rx_q;
          oloc_d  = '0;
          ost_d   = ST_UNC;
          state_d = S_DONE;
        end else begin
          cw_d    = fx[AN_CW_W-1:0];
          r_d     = '0;
          q_d     = '0;
          cnt_d   = '0;
          state_d = S_DIV2;
        end
      end
      S_DIV2: begin
        r_d   = step_rem;
        q_d   = q_shift;
        cnt_d = cnt_q + 6'd1;
        if (last_step) begin
          od_d = q_shift[AN_DATA_W-1:0];
          if (qs_hi_nz) begin
            ost_d  = ST_UNC;
            ocw_d  = rx_q;
            oloc_d = '0;
          end else begin
            ost_d  = ST_CORR;
            ocw_d  = cw_q;
            oloc_d = l_q;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A clear on the handshake edge wins, and that word goes uncounted.
    if (cnt_clr) begin
      corr_d = '0;
      unc_d  = '0;
    end else if (state_q == S_DONE && out_ready) begin
      if (ost_q == ST_CORR && corr_q != {CNT_W{1'b1}}) begin
        corr_d = corr_q + CNT_W'(1);
      end
      if (ost_q == ST_UNC && unc_q != {CNT_W{1'b1}}) begin
        unc_d = unc_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rx_q    <= '0;
      cw_q    <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      l_q     <= '0;
      od_q    <= '0;
      ocw_q   <= '0;
      ost_q   <= ST_CLEAN;
      oloc_q  <= '0;
      corr_q  <= '0;
      unc_q   <= '0;
    end else begin
      state_q <= state_d;
      rx_q    <= rx_d;
      cw_q    <= cw_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      od_q    <= od_d;
      ocw_q   <= ocw_d;
      ost_q   <= ost_d;
      oloc_q  <= oloc_d;
      corr_q  <= corr_d;
      unc_q   <= unc_d;
    end
  end

  // A corrected word is a multiple of A by construction; a remainder here
  // means the LUT or correction arithmetic is broken.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == S_DIV2 && last_step) begin
      assert (step_rem == '0);
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_data   = od_q;
  assign out_cw     = ocw_q;
  assign out_status = ost_q;
  assign out_loc    = oloc_q;
  assign corr_cnt   = corr_q;
  assign unc_cnt    = unc_q;

endmodule

// File: tb/tb_an_sec_decode_ctrl.sv
// tb/tb_an_sec_decode_ctrl.sv - directed self-checking bench for an_sec_decode_ctrl
module tb_an_sec_decode_ctrl;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [32:0]       in_cw;
  logic              out_valid;
  logic              out_ready;
  logic [19:0]       out_data;
  logic [32:0]       out_cw;
  logic [1:0]        out_status;
  logic signed [6:0] out_loc;
  logic              cnt_clr;
  logic [1:0]        corr_cnt;
  logic [1:0]        unc_cnt;

  int checks = 0;
  int errors = 0;

  an_sec_decode_ctrl #(.CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cw      (in_cw),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_cw     (out_cw),
    .out_status (out_status),
    .out_loc    (out_loc),
    .cnt_clr    (cnt_clr),
    .corr_cnt   (corr_cnt),
    .unc_cnt    (unc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_out_cw"}, 64'(out_cw), 64'd0);
    chk({tag, "_out_status"}, 64'(out_status), 64'd0);
    chk({tag, "_out_loc"}, 64'({1'b0, out_loc}), 64'd0);
    chk({tag, "_corr_cnt"}, 64'(corr_cnt), 64'd0);
    chk({tag, "_unc_cnt"}, 64'(unc_cnt), 64'd0);
  endtask

  // Present one codeword, wait (bounded) for out_valid, check latency and result.
  task automatic run(input string tag, input logic [32:0] cw, input logic [1:0] st,
                     input logic [19:0] data, input logic [32:0] ocw,
                     input logic [6:0] loc, input int lat);
    int n;
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_cw    = cw;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_status"}, 64'(out_status), 64'(st));
    chk({tag, "_data"}, 64'(out_data), 64'(data));
    chk({tag, "_out_cw"}, 64'(out_cw), 64'(ocw));
    chk({tag, "_loc"}, 64'({1'b0, out_loc}), 64'(loc));
  endtask

  task automatic ack(input string tag, input logic clr);
    out_ready = 1'b1;
    cnt_clr   = clr;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    chk({tag, "_in_ready_after_hs"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_cw     = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;

    run("clean", 33'd31555, 2'b00, 20'd5, 33'd31555, 7'd0, 34);
    ack("clean", 1'b0);
    chk("clean_corr_cnt", 64'(corr_cnt), 64'd0);
    chk("clean_unc_cnt", 64'(unc_cnt), 64'd0);

    run("pos", 33'd39747, 2'b01, 20'd5, 33'd31555, 7'd14, 68);
    ack("pos", 1'b0);
    chk("pos_corr_cnt", 64'(corr_cnt), 64'd1);

    run("neg", 33'd6310999, 2'b01, 20'd1000, 33'd6311000, 7'h7F, 68);
    ack("neg", 1'b0);
    chk("neg_corr_cnt", 64'(corr_cnt), 64'd2);

    run("unc", 33'd31558, 2'b10, 20'd5, 33'd31558, 7'd0, 34);
    ack("unc", 1'b0);
    chk("unc_unc_cnt", 64'(unc_cnt), 64'd1);

    // r = 1881 locates +2^13, but 1881 - 8192 borrows: rejected in FIX.
    run("borrow", 33'd1881, 2'b10, 20'd0, 33'd1881, 7'd0, 35);
    ack("borrow", 1'b0);
    chk("borrow_unc_cnt", 64'(unc_cnt), 64'd2);

    // 6311 * 2^20: remainder 0 but quotient exceeds 20 bits.
    run("range", 33'd6617563136, 2'b10, 20'd0, 33'd6617563136, 7'd0, 34);
    ack("range", 1'b0);
    chk("range_unc_cnt", 64'(unc_cnt), 64'd3);

    run("bp", 33'd39747, 2'b01, 20'd5, 33'd31555, 7'd14, 68);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_data", 64'(out_data), 64'd5);
      chk("bp_out_cw", 64'(out_cw), 64'd31555);
    end
    ack("bp", 1'b0);
    chk("bp_corr_cnt", 64'(corr_cnt), 64'd3);

    // Reset in the middle of DIV2 drops the word and clears everything.
    @(negedge clk);
    in_valid = 1'b1;
    in_cw    = 33'd39747;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (45) @(posedge clk);
    @(negedge clk);
    chk("mid_busy_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_state("midrst");
    rst_n = 1'b1;

    run("after_rst", 33'd6310999, 2'b01, 20'd1000, 33'd6311000, 7'h7F, 68);
    ack("after_rst", 1'b0);
    chk("after_rst_corr_cnt", 64'(corr_cnt), 64'd1);

    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_corr_cnt", 64'(corr_cnt), 64'd0);

    for (int k = 1; k <= 5; k++) begin
      run("sat", 33'd39747, 2'b01, 20'd5, 33'd31555, 7'd14, 68);
      ack("sat", 1'b0);
      chk("sat_corr_cnt", 64'(corr_cnt), 64'((k > 3) ? 3 : k));
    end

    run("clr_inc", 33'd39747, 2'b01, 20'd5, 33'd31555, 7'd14, 68);
    ack("clr_inc", 1'b1);
    chk("clr_inc_corr_cnt", 64'(corr_cnt), 64'd0);
    chk("clr_inc_unc_cnt", 64'(unc_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
